// File: rtl/rename_reg_file_pkg.sv
// Shared constants for the rename register file slice.
//   REG_NUM   : number of architectural registers (x0 hard-wired to zero)
//   REG_IDX_W : register index width
//   ROB_ID_W  : ROB id width on every port; id 0 is never issued
//   DATA_W    : register value width
package rename_reg_file_pkg;

  localparam int unsigned REG_NUM   = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned ROB_ID_W  = 32;
  localparam int unsigned DATA_W    = 32;

endpackage

// File: rtl/rename_reg_file_if.sv
// Bus between decode / ROB (master) and the rename register file (slave).
//   rdy, jump_wrong_flag      : global enable and one-cycle flush pulse
//   ID_rename_*               : decode destination mapping at issue
//   ID_rs1/ID_rs2             : source operand indices
//   RS1_*/RS2_*               : resolved operands (ready/value/producing ROB id)
//   RF_id1/RF_id2             : ROB ids queried for in-flight results
//   RF_id1_*/RF_id2_*         : ROB answer to those queries
//   ROB_cmt_rf_*              : commit write-back
interface rename_reg_file_if;
  import rename_reg_file_pkg::*;

  logic                 rdy;
  logic                 jump_wrong_flag;

  logic                 ID_rename_flag;
  logic [REG_IDX_W-1:0] ID_rename_rd;
  logic [ROB_ID_W-1:0]  ID_rename_rob_id;
  logic [REG_IDX_W-1:0] ID_rs1;
  logic [REG_IDX_W-1:0] ID_rs2;

  logic                 RS1_ready;
  logic [DATA_W-1:0]    RS1_val;
  logic [ROB_ID_W-1:0]  RS1_rob_id;
  logic                 RS2_ready;
  logic [DATA_W-1:0]    RS2_val;
  logic [ROB_ID_W-1:0]  RS2_rob_id;

  logic [ROB_ID_W-1:0]  RF_id1;
  logic [ROB_ID_W-1:0]  RF_id2;
  logic                 RF_id1_ready;
  logic [DATA_W-1:0]    RF_id1_val;
  logic                 RF_id2_ready;
  logic [DATA_W-1:0]    RF_id2_val;

  logic                 ROB_cmt_rf_flag;
  logic [REG_IDX_W-1:0] ROB_cmt_rf_rd;
  logic [ROB_ID_W-1:0]  ROB_cmt_rf_rob_id;
  logic [DATA_W-1:0]    ROB_cmt_rf_val;

  modport master (
    output rdy, jump_wrong_flag,
    output ID_rename_flag, ID_rename_rd, ID_rename_rob_id, ID_rs1, ID_rs2,
    input  RS1_ready, RS1_val, RS1_rob_id, RS2_ready, RS2_val, RS2_rob_id,
    input  RF_id1, RF_id2,
    output RF_id1_ready, RF_id1_val, RF_id2_ready, RF_id2_val,
    output ROB_cmt_rf_flag, ROB_cmt_rf_rd, ROB_cmt_rf_rob_id, ROB_cmt_rf_val
  );

  modport slave (
    input  rdy, jump_wrong_flag,
    input  ID_rename_flag, ID_rename_rd, ID_rename_rob_id, ID_rs1, ID_rs2,
    output RS1_ready, RS1_val, RS1_rob_id, RS2_ready, RS2_val, RS2_rob_id,
    output RF_id1, RF_id2,
    input  RF_id1_ready, RF_id1_val, RF_id2_ready, RF_id2_val,
    input  ROB_cmt_rf_flag, ROB_cmt_rf_rd, ROB_cmt_rf_rob_id, ROB_cmt_rf_val
  );
endinterface

// File: rtl/rename_reg_file_rf_read_port.sv
// Combinational operand resolve for one source port.
//   rs / busy / tag / rf_val : register index and its stored state
//   cmt_*                    : commit bus, used as a same-cycle bypass
//   rob_ready / rob_val      : ROB answer for the queried tag
//   ready / val / rob_id     : resolved operand (val=0 when not ready, rob_id=0 when ready)
//   rf_id                    : ROB id to query (0 when the register is unmapped)
module rf_read_port
  import rename_reg_file_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs,
  input  logic                 busy,
  input  logic [ROB_ID_W-1:0]  tag,
  input  logic [DATA_W-1:0]    rf_val,
  input  logic                 cmt_flag,
  input  logic [REG_IDX_W-1:0] cmt_rd,
  input  logic [ROB_ID_W-1:0]  cmt_rob_id,
  input  logic [DATA_W-1:0]    cmt_val,
  input  logic                 rob_ready,
  input  logic [DATA_W-1:0]    rob_val,
  output logic                 ready,
  output logic [DATA_W-1:0]    val,
  output logic [ROB_ID_W-1:0]  rob_id,
  output logic [ROB_ID_W-1:0]  rf_id
);

  always_comb begin
    ready  = 1'b1;
    val    = rf_val;
    rob_id = '0;
    rf_id  = busy ? tag : '0;
    if (rs == '0 || !busy) begin
      val = rf_val;
    end else if (cmt_flag && cmt_rd == rs && cmt_rob_id == tag) begin
      // Producer is committing this very cycle.
      val = cmt_val;
    end else if (rob_ready) begin
      val = rob_val;
    end else begin
      ready  = 1'b0;
      val    = '0;
      rob_id = tag;
    end
  end

endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register rename tag.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : decode / ROB bus (slave side), see rename_reg_file_if
// Decode maps rd to a ROB id at issue; commit writes values back and clears
// the mapping only when the committing id is still the current tag.
module rename_reg_file
  import rename_reg_file_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  rename_reg_file_if.slave bus
);

  logic [DATA_W-1:0]   val_q [REG_NUM];
  logic [ROB_ID_W-1:0] tag_q [REG_NUM];
  logic [REG_NUM-1:0]  busy_q;

  // Later non-blocking writes win: rename overrides a same-cycle commit on
  // busy/tag, and flush overrides both.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (bus.rdy) begin
      if (bus.ROB_cmt_rf_flag && bus.ROB_cmt_rf_rd != '0) begin
        val_q[bus.ROB_cmt_rf_rd] <= bus.ROB_cmt_rf_val;
        if (tag_q[bus.ROB_cmt_rf_rd] == bus.ROB_cmt_rf_rob_id)
          busy_q[bus.ROB_cmt_rf_rd] <= 1'b0;
      end
      if (bus.jump_wrong_flag) begin
        busy_q <= '0;
        for (int unsigned i = 0; i < REG_NUM; i++)
          tag_q[i] <= '0;
      end else if (bus.ID_rename_flag && bus.ID_rename_rd != '0) begin
        busy_q[bus.ID_rename_rd] <= 1'b1;
        tag_q[bus.ID_rename_rd]  <= bus.ID_rename_rob_id;
      end
    end
  end

  rf_read_port u_port1 (
    .rs         (bus.ID_rs1),
    .busy       (busy_q[bus.ID_rs1]),
    .tag        (tag_q[bus.ID_rs1]),
    .rf_val     (val_q[bus.ID_rs1]),
    .cmt_flag   (bus.ROB_cmt_rf_flag),
    .cmt_rd     (bus.ROB_cmt_rf_rd),
    .cmt_rob_id (bus.ROB_cmt_rf_rob_id),
    .cmt_val    (bus.ROB_cmt_rf_val),
    .rob_ready  (bus.RF_id1_ready),
    .rob_val    (bus.RF_id1_val),
    .ready      (bus.RS1_ready),
    .val        (bus.RS1_val),
    .rob_id     (bus.RS1_rob_id),
    .rf_id      (bus.RF_id1)
  );

  rf_read_port u_port2 (
    .rs         (bus.ID_rs2),
    .busy       (busy_q[bus.ID_rs2]),
    .tag        (tag_q[bus.ID_rs2]),
    .rf_val     (val_q[bus.ID_rs2]),
    .cmt_flag   (bus.ROB_cmt_rf_flag),
    .cmt_rd     (bus.ROB_cmt_rf_rd),
    .cmt_rob_id (bus.ROB_cmt_rf_rob_id),
    .cmt_val    (bus.ROB_cmt_rf_val),
    .rob_ready  (bus.RF_id2_ready),
    .rob_val    (bus.RF_id2_val),
    .ready      (bus.RS2_ready),
    .val        (bus.RS2_val),
    .rob_id     (bus.RS2_rob_id),
    .rf_id      (bus.RF_id2)
  );

endmodule

// File: tb/tb_rename_reg_file.sv
module tb_rename_reg_file;
  import rename_reg_file_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rename_reg_file_if bus ();

  rename_reg_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference state: what each architectural register holds and whom it waits on.
  logic [31:0] m_val  [REG_NUM];
  bit          m_busy [REG_NUM];
  logic [31:0] m_tag  [REG_NUM];

  // ROB side: results already computed by in-flight entries.
  logic [31:0] rob_res [int unsigned];

  typedef struct { logic [4:0] rd; logic [31:0] id; } inflight_t;
  inflight_t inflight [$];

  task automatic check(input string tag_s, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag_s, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < REG_NUM; i++) begin
      m_val[i]  = '0;
      m_busy[i] = 1'b0;
      m_tag[i]  = '0;
    end
  endtask

  task automatic clear_inputs();
    bus.rdy               = 1'b1;
    bus.jump_wrong_flag   = 1'b0;
    bus.ID_rename_flag    = 1'b0;
    bus.ID_rename_rd      = '0;
    bus.ID_rename_rob_id  = '0;
    bus.ID_rs1            = '0;
    bus.ID_rs2            = '0;
    bus.RF_id1_ready      = 1'b0;
    bus.RF_id1_val        = '0;
    bus.RF_id2_ready      = 1'b0;
    bus.RF_id2_val        = '0;
    bus.ROB_cmt_rf_flag   = 1'b0;
    bus.ROB_cmt_rf_rd     = '0;
    bus.ROB_cmt_rf_rob_id = '0;
    bus.ROB_cmt_rf_val    = '0;
  endtask

  // Expected operand for register rs given the ROB's answer for that port.
  task automatic check_port(input string nm, input logic [4:0] rs,
                            input logic rr, input logic [31:0] rv,
                            input logic a_rdy, input logic [31:0] a_val,
                            input logic [31:0] a_id, input logic [31:0] a_rfid);
    logic        e_rdy;
    logic [31:0] e_val, e_id;
    e_rdy = 1'b1; e_val = m_val[rs]; e_id = '0;
    if (rs != 0 && m_busy[rs]) begin
      if (bus.ROB_cmt_rf_flag && bus.ROB_cmt_rf_rd == rs && bus.ROB_cmt_rf_rob_id == m_tag[rs])
        e_val = bus.ROB_cmt_rf_val;
      else if (rr)
        e_val = rv;
      else begin
        e_rdy = 1'b0; e_val = '0; e_id = m_tag[rs];
      end
    end
    check({nm, "_ready"},  {31'b0, a_rdy}, {31'b0, e_rdy});
    check({nm, "_val"},    a_val, e_val);
    check({nm, "_rob_id"}, a_id, e_id);
    check({nm, "_rf_id"},  a_rfid, m_busy[rs] ? m_tag[rs] : 32'h0);
  endtask

  task automatic model_update();
    if (!bus.rdy) return;
    if (bus.ROB_cmt_rf_flag && bus.ROB_cmt_rf_rd != 0) begin
      m_val[bus.ROB_cmt_rf_rd] = bus.ROB_cmt_rf_val;
      if (m_tag[bus.ROB_cmt_rf_rd] == bus.ROB_cmt_rf_rob_id)
        m_busy[bus.ROB_cmt_rf_rd] = 1'b0;
    end
    if (bus.jump_wrong_flag) begin
      for (int i = 0; i < REG_NUM; i++) begin
        m_busy[i] = 1'b0;
        m_tag[i]  = '0;
      end
    end else if (bus.ID_rename_flag && bus.ID_rename_rd != 0) begin
      m_busy[bus.ID_rename_rd] = 1'b1;
      m_tag[bus.ID_rename_rd]  = bus.ID_rename_rob_id;
    end
  endtask

  // Inputs are applied just after a falling edge; outputs checked 1 time unit later.
  task automatic cycle();
    #1;
    check_port("rs1", bus.ID_rs1, bus.RF_id1_ready, bus.RF_id1_val,
               bus.RS1_ready, bus.RS1_val, bus.RS1_rob_id, bus.RF_id1);
    check_port("rs2", bus.ID_rs2, bus.RF_id2_ready, bus.RF_id2_val,
               bus.RS2_ready, bus.RS2_val, bus.RS2_rob_id, bus.RF_id2);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic rename(input logic [4:0] rd, input logic [31:0] id);
    clear_inputs();
    bus.ID_rename_flag = 1'b1; bus.ID_rename_rd = rd; bus.ID_rename_rob_id = id;
    cycle();
  endtask

  initial begin
    logic [31:0] next_id;
    bit          do_cmt, do_ren;
    logic [31:0] id1, id2;

    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_ready", {31'b0, bus.RS1_ready}, 32'h1);
    check("reset_val",   bus.RS1_val, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // 1: asynchronous reset while x5 is busy
    rename(5'd5, 32'd1);
    clear_inputs(); bus.ID_rs1 = 5'd5;
    #1 check("t1_busy_before", {31'b0, bus.RS1_ready}, 32'h0);
    rst = 1'b0;
    #1;
    check("t1_async_ready", {31'b0, bus.RS1_ready}, 32'h1);
    check("t1_async_val",   bus.RS1_val, 32'h0);
    check("t1_async_rfid",  bus.RF_id1, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 2: rename then matching commit
    rename(5'd3, 32'd7);
    clear_inputs(); bus.ID_rs1 = 5'd3;
    bus.ROB_cmt_rf_flag = 1'b1; bus.ROB_cmt_rf_rd = 5'd3;
    bus.ROB_cmt_rf_rob_id = 32'd7; bus.ROB_cmt_rf_val = 32'h55;
    cycle();
    clear_inputs(); bus.ID_rs1 = 5'd3;
    #1;
    check("t2_ready", {31'b0, bus.RS1_ready}, 32'h1);
    check("t2_val",   bus.RS1_val, 32'h55);
    check("t2_rfid",  bus.RF_id1, 32'h0);
    cycle();

    // 3: older commit must not clear a newer mapping
    rename(5'd3, 32'd7);
    rename(5'd3, 32'd9);
    clear_inputs();
    bus.ROB_cmt_rf_flag = 1'b1; bus.ROB_cmt_rf_rd = 5'd3;
    bus.ROB_cmt_rf_rob_id = 32'd7; bus.ROB_cmt_rf_val = 32'h1;
    cycle();
    clear_inputs(); bus.ID_rs1 = 5'd3;
    #1;
    check("t3_ready",  {31'b0, bus.RS1_ready}, 32'h0);
    check("t3_rob_id", bus.RS1_rob_id, 32'd9);
    check("t3_val",    bus.RS1_val, 32'h0);
    cycle();
    clear_inputs(); bus.jump_wrong_flag = 1'b1;
    cycle();
    clear_inputs(); bus.ID_rs1 = 5'd3;
    #1 check("t3_stored_val", bus.RS1_val, 32'h1);
    cycle();

    // 4: ROB forward, then commit bypass taking priority
    rename(5'd4, 32'd12);
    clear_inputs(); bus.ID_rs1 = 5'd4;
    bus.RF_id1_ready = 1'b1; bus.RF_id1_val = 32'hAB;
    #1;
    check("t4_fwd_ready", {31'b0, bus.RS1_ready}, 32'h1);
    check("t4_fwd_val",   bus.RS1_val, 32'hAB);
    check("t4_rfid",      bus.RF_id1, 32'd12);
    bus.ROB_cmt_rf_flag = 1'b1; bus.ROB_cmt_rf_rd = 5'd4;
    bus.ROB_cmt_rf_rob_id = 32'd12; bus.ROB_cmt_rf_val = 32'hCD;
    #1 check("t4_bypass_val", bus.RS1_val, 32'hCD);
    cycle();

    // 5: flush with same-cycle commit and rename
    rename(5'd1, 32'd4);
    rename(5'd2, 32'd3);
    clear_inputs(); bus.jump_wrong_flag = 1'b1;
    bus.ROB_cmt_rf_flag = 1'b1; bus.ROB_cmt_rf_rd = 5'd1;
    bus.ROB_cmt_rf_rob_id = 32'd4; bus.ROB_cmt_rf_val = 32'h100;
    bus.ID_rename_flag = 1'b1; bus.ID_rename_rd = 5'd2; bus.ID_rename_rob_id = 32'd5;
    cycle();
    clear_inputs(); bus.ID_rs1 = 5'd1; bus.ID_rs2 = 5'd2;
    #1;
    check("t5_x1_val",   bus.RS1_val, 32'h100);
    check("t5_x2_ready", {31'b0, bus.RS2_ready}, 32'h1);
    check("t5_x2_rfid",  bus.RF_id2, 32'h0);
    cycle();

    // 6: x0 is never written; rdy=0 holds state
    clear_inputs();
    bus.ID_rename_flag = 1'b1; bus.ID_rename_rd = 5'd0; bus.ID_rename_rob_id = 32'd20;
    bus.ROB_cmt_rf_flag = 1'b1; bus.ROB_cmt_rf_rd = 5'd0;
    bus.ROB_cmt_rf_rob_id = 32'd20; bus.ROB_cmt_rf_val = 32'hFFFF;
    cycle();
    clear_inputs();
    #1;
    check("t6_x0_ready", {31'b0, bus.RS1_ready}, 32'h1);
    check("t6_x0_val",   bus.RS1_val, 32'h0);
    bus.rdy = 1'b0;
    bus.ID_rename_flag = 1'b1; bus.ID_rename_rd = 5'd6; bus.ID_rename_rob_id = 32'd21;
    cycle();
    clear_inputs(); bus.ID_rs1 = 5'd6;
    #1;
    check("t6_hold_ready", {31'b0, bus.RS1_ready}, 32'h1);
    check("t6_hold_rfid",  bus.RF_id1, 32'h0);
    cycle();

    // Randomized traffic: in-order commits, occasional flush and stalls.
    next_id = 32'd100;
    for (int n = 0; n < 3000; n++) begin
      clear_inputs();
      bus.rdy             = ($urandom_range(0, 9) != 0);
      bus.jump_wrong_flag = ($urandom_range(0, 59) == 0);
      bus.ID_rs1          = 5'($urandom_range(0, 7));
      bus.ID_rs2          = 5'($urandom_range(0, 7));
      do_ren = ($urandom_range(0, 2) != 0);
      if (do_ren) begin
        bus.ID_rename_flag   = 1'b1;
        bus.ID_rename_rd     = 5'($urandom_range(0, 7));
        bus.ID_rename_rob_id = next_id;
      end
      do_cmt = (inflight.size() != 0) && ($urandom_range(0, 1) != 0);
      if (do_cmt) begin
        bus.ROB_cmt_rf_flag   = 1'b1;
        bus.ROB_cmt_rf_rd     = inflight[0].rd;
        bus.ROB_cmt_rf_rob_id = inflight[0].id;
        bus.ROB_cmt_rf_val    = rob_res.exists(inflight[0].id) ? rob_res[inflight[0].id] : $urandom;
      end
      id1 = m_busy[bus.ID_rs1] ? m_tag[bus.ID_rs1] : 32'h0;
      id2 = m_busy[bus.ID_rs2] ? m_tag[bus.ID_rs2] : 32'h0;
      bus.RF_id1_ready = (id1 != 0) && rob_res.exists(id1) && ($urandom_range(0, 3) != 0);
      bus.RF_id1_val   = bus.RF_id1_ready ? rob_res[id1] : $urandom;
      bus.RF_id2_ready = (id2 != 0) && rob_res.exists(id2) && ($urandom_range(0, 3) != 0);
      bus.RF_id2_val   = bus.RF_id2_ready ? rob_res[id2] : $urandom;
      cycle();
      if (bus.rdy) begin
        if (do_cmt) void'(inflight.pop_front());
        if (bus.jump_wrong_flag) inflight.delete();
        else if (do_ren) begin
          inflight.push_back('{rd: bus.ID_rename_rd, id: next_id});
          if ($urandom_range(0, 1) != 0) rob_res[next_id] = $urandom;
          next_id++;
        end
      end
      // Let in-flight entries finish their results over time.
      if (inflight.size() != 0 && $urandom_range(0, 2) == 0) begin
        int k;
        k = $urandom_range(0, inflight.size() - 1);
        if (!rob_res.exists(inflight[k].id)) rob_res[inflight[k].id] = $urandom;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
